fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the PC/fetch stage and the decode stage. Buffers up to DEPTH {pc, instruction} pairs so that fetch keeps running while decode stalls. Provides a valid/ready handshake on both sides and a flush input driven by the jump redirect, which discards all wrong-path entries.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; the queue is in reset while reset==0
- in_valid  input  1  fetch presents a pair
- in_pc  input  32  PC of the fetched instruction
- in_instr  input  32  fetched instruction word
- in_ready  output  1  queue can accept; equals !full
- flush  input  1  redirect (jump taken); discard all contents
- out_valid  output  1  pair available to decode
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction of the head entry
- out_ready  input  1  decode accepts the head
- count  output  CNT_W  current occupancy, 0..DEPTH

## Operation
- Circular buffer with rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1→0) and a separate count register. full = (count==DEPTH). empty = (count==0).
- push = in_valid & in_ready & !flush. It writes {in_pc, in_instr} at wr_ptr, then wr_ptr+1.
- pop = out_valid & out_ready & !flush. It advances rd_ptr.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: in_ready=0. No push occurs, even if a pop happens in the same cycle; there is no pass-through when full.
- Empty: out_valid=0. The pop request is ignored.
- Flush has priority over push and pop. On the next edge, count=0, rd_ptr=wr_ptr=0, and any input presented in the flush cycle is dropped. Storage is not cleared.
- out_pc and out_instr show the entry at rd_ptr when out_valid=1. They are forced to 0 when out_valid=0 (bypass case excepted, see Configuration).
- Reset (asynchronous, mid-operation included): count=0, pointers=0, storage=0, out_valid=0, in_ready=1, out_pc=out_instr=0, count output=0.

## Timing
- A push at edge N appears on the outputs after edge N. Minimum latency is 1 cycle (0 with bypass).
- out_valid, in_ready and count depend only on registered state. They have no combinational path from in_valid, out_ready or flush, except out_valid in bypass mode.
- Flush asserted in cycle N: out_valid=0 from edge N onward, until a new push at edge ≥N+1 lands.
- Throughput is one pair per cycle in steady state when neither side stalls.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty and flush=0, out_valid=in_valid and out_pc/out_instr=in_pc/in_instr combinationally.
  - If out_ready=1 in that cycle, the pair is consumed directly and not written; count stays 0.
  - If out_ready=0, the pair is pushed normally.
- Not defined: no combinational in→out path; an empty queue always gives 1-cycle latency.

## Structure
- Shared package fetch_pkg holds:
  - INSTR_W=32 and PC_W=32 constants
  - typedef fetch_entry_t {pc, instr}
  - default DEPTH constant, also used by the decode stage
- One natural sub-module, fetch_queue_mem: a DEPTH×fetch_entry_t register array with synchronous write and asynchronous read, cleared on reset. Pointer, count and handshake logic stays in fetch_queue.

## Test plan
- Reset release, then push pc=0x0/0x4/0x8 with out_ready=0 → count=3, out_pc=0x0, in_ready=1. Then pop three cycles → out_pc sequence 0x0, 0x4, 0x8; count=0, out_valid=0.
- Fill DEPTH=4 (pc 0x10..0x1C) → in_ready=0, count=4. Then assert in_valid with out_ready=1 for one cycle → pop only; count=3, 0x20 is not stored.
- Continuous push and pop for 10 cycles starting from count=2 → count stays 2, pointer wrap is exercised, output order matches input order.
- Flush with count=3 while in_valid=1 (pc 0x40) → next cycle count=0, out_valid=0. 0x40 is dropped; the next push of pc 0x100 is output first.
- Assert reset (reset=0) asynchronously mid-cycle with count=2 → outputs go to 0/in_ready=1 immediately, without waiting for a clock edge.
- Bypass build, empty queue, in_valid=1, pc=0x200, out_ready=1 → out_valid=1, out_pc=0x200 in the same cycle, count stays 0. Non-bypass build → out_valid=0 in that cycle and 0x200 appears after the edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants, used by fetch_queue and the decode stage.
package fetch_pkg;

  localparam int INSTR_W           = 32;
  localparam int PC_W              = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: synchronous write, asynchronous read, cleared on reset.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  fetch_entry_t     wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output fetch_entry_t     rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // NOTE: the array is explicitly cleared on reset, which keeps it in flops
  // rather than a RAM macro; acceptable at this small depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode, with flush on redirect.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue combinational pass-through.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FETCH_QUEUE_DEPTH,
  parameter  int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty;
  logic             push, pop, bypass_take;
  fetch_entry_t     head_entry, out_entry;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    out_valid   = !empty;
    out_entry   = '0;
    bypass_take = 1'b0;
    if (!empty) out_entry = head_entry;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && !flush) begin
      out_valid   = in_valid;
      out_entry   = in_valid ? fetch_entry_t'{pc: in_pc, instr: in_instr} : '0;
      bypass_take = in_valid && out_ready;
    end
`endif
  end

  assign out_pc    = out_entry.pc;
  assign out_instr = out_entry.instr;

  // A bypassed pair is consumed straight from the inputs and never stored.
  assign push = in_valid && in_ready && !flush && !bypass_take;
  assign pop  = out_valid && out_ready && !flush && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (fetch_entry_t'{pc: in_pc, instr: in_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table plus scoreboard-driven sequences.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_pc = '0;
  logic [31:0]      in_instr = '0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    int          cnt;
    logic        v;
    logic [31:0] opc;
    logic        rdy;
  } vec_t;

  vec_t vecs[16];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] pc, input logic ordy,
                               input int cnt, input logic v, input logic [31:0] opc,
                               input logic rdy);
    vec_t r;
    r.iv = iv; r.pc = pc; r.ordy = ordy; r.fl = 1'b0;
    r.cnt = cnt; r.v = v; r.opc = opc; r.rdy = rdy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid = iv; in_pc = pc; in_instr = mk_instr(pc); out_ready = ordy; flush = fl;
  endtask

  // One clock cycle checked against the scoreboard model; model updates at the edge.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    int          sz;
    logic        e_v, byp;
    logic [31:0] e_pc;
    drive(iv, pc, ordy, fl);
    #4;
    sz   = sb_q.size();
    e_v  = (sz != 0);
    e_pc = e_v ? sb_q[0] : 32'h0;
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (sz == 0 && !fl && iv) begin e_v = 1'b1; e_pc = pc; byp = 1'b1; end
`endif
    check({tag, ".count"},     32'(count),   32'(sz));
    check({tag, ".in_ready"},  32'(in_ready), 32'(sz < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
    check({tag, ".out_pc"},    out_pc,    e_v ? e_pc : 32'h0);
    check({tag, ".out_instr"}, out_instr, e_v ? mk_instr(e_pc) : 32'h0);
    @(posedge clock); #1;
    if (fl) sb_q.delete();
    else if (!(byp && ordy)) begin
      if (sz > 0 && ordy) void'(sb_q.pop_front());
      if (iv && sz < DEPTH) sb_q.push_back(pc);
    end
  endtask

  initial begin
    vecs[0]  = mkv(1, 32'h00, 0, 0, 0, 32'h00, 1);
    vecs[1]  = mkv(1, 32'h04, 0, 1, 1, 32'h00, 1);
    vecs[2]  = mkv(1, 32'h08, 0, 2, 1, 32'h00, 1);
    vecs[3]  = mkv(0, 32'h00, 1, 3, 1, 32'h00, 1);
    vecs[4]  = mkv(0, 32'h00, 1, 2, 1, 32'h04, 1);
    vecs[5]  = mkv(0, 32'h00, 1, 1, 1, 32'h08, 1);
    vecs[6]  = mkv(0, 32'h00, 0, 0, 0, 32'h00, 1);
    vecs[7]  = mkv(1, 32'h10, 0, 0, 0, 32'h00, 1);
    vecs[8]  = mkv(1, 32'h14, 0, 1, 1, 32'h10, 1);
    vecs[9]  = mkv(1, 32'h18, 0, 2, 1, 32'h10, 1);
    vecs[10] = mkv(1, 32'h1C, 0, 3, 1, 32'h10, 1);
    vecs[11] = mkv(1, 32'h20, 1, 4, 1, 32'h10, 0);
    vecs[12] = mkv(0, 32'h00, 1, 3, 1, 32'h14, 1);
    vecs[13] = mkv(0, 32'h00, 1, 2, 1, 32'h18, 1);
    vecs[14] = mkv(0, 32'h00, 1, 1, 1, 32'h1C, 1);
    vecs[15] = mkv(0, 32'h00, 0, 0, 0, 32'h00, 1);

    // Reset state while held in reset.
    #2;
    check("rst.count",     32'(count),     32'h0);
    check("rst.in_ready",  32'(in_ready),  32'h1);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.out_pc",    out_pc,         32'h0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    // Vector table: push/pop order, then fill to full and pop-only while full.
    for (int i = 0; i < 16; i++) begin
      logic        e_v;
      logic [31:0] e_pc;
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      #4;
      e_v  = vecs[i].v;
      e_pc = vecs[i].opc;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (vecs[i].cnt == 0 && vecs[i].iv && !vecs[i].fl) begin e_v = 1'b1; e_pc = vecs[i].pc; end
`endif
      check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].cnt));
      check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].rdy));
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(e_v));
      check($sformatf("vec%0d.out_pc", i),    out_pc,         e_pc);
      check($sformatf("vec%0d.out_instr", i), out_instr,      e_v ? mk_instr(e_pc) : 32'h0);
      @(posedge clock); #1;
    end

    // Steady streaming from count=2 with pointer wrap.
    cycle("st_fill", 1, 32'h1000, 0, 0);
    cycle("st_fill", 1, 32'h1004, 0, 0);
    for (int i = 0; i < 10; i++) cycle("stream", 1, 32'h2000 + 32'(i * 4), 1, 0);
    for (int i = 0; i < 3; i++)  cycle("drain", 0, 32'h0, 1, 0);

    // Flush with count=3 while a new pair is offered; it must be dropped.
    cycle("fl_fill", 1, 32'h30, 0, 0);
    cycle("fl_fill", 1, 32'h34, 0, 0);
    cycle("fl_fill", 1, 32'h38, 0, 0);
    cycle("flush",   1, 32'h40, 0, 1);
    cycle("post_fl", 0, 32'h0,  0, 0);
    cycle("post_fl", 1, 32'h100, 0, 0);
    cycle("post_fl", 0, 32'h0,  1, 0);
    cycle("post_fl", 0, 32'h0,  0, 0);

    // Asynchronous reset mid-cycle with count=2.
    cycle("ar_fill", 1, 32'h300, 0, 0);
    cycle("ar_fill", 1, 32'h304, 0, 0);
    drive(0, 32'h0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("arst.count",     32'(count),     32'h0);
    check("arst.in_ready",  32'(in_ready),  32'h1);
    check("arst.out_valid", 32'(out_valid), 32'h0);
    check("arst.out_pc",    out_pc,         32'h0);
    check("arst.out_instr", out_instr,      32'h0);
    sb_q.delete();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    cycle("post_rst", 0, 32'h0, 0, 0);

    // Empty queue, pair offered with decode ready: bypass or 1-cycle latency.
    cycle("byp", 1, 32'h200, 1, 0);
    cycle("byp_next", 0, 32'h0, 1, 0);
    cycle("byp_idle", 0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
